// File: rtl/pipeline_regs_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_regs_if
//  Description : Bundle of IF/ID, ID/EX and EX/MEM pipeline-register signals.
//                The "slave" modport is the register bank, the "master"
//                modport is the surrounding pipeline (or a testbench).
//                Optional macro PIPE_FLUSH_EN adds if_id_flush/id_ex_flush.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_regs_if;

    // IF/ID
    logic        if_id_enable;
    logic [31:0] instr;
    logic [63:0] pcaddr;
    logic [31:0] instr_out;
    logic [63:0] pcaddr_out;

    // ID/EX
    logic        id_ex_enable;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [63:0] PCaddr;
    logic [63:0] se;
    logic [4:0]  Rn;
    logic [4:0]  Rm;
    logic [4:0]  Rd;
    logic [5:0]  cntrl_EX;
    logic [4:0]  cntrl_M;
    logic [1:0]  cntrl_WB;
    logic [63:0] RD1_out;
    logic [63:0] RD2_out;
    logic [63:0] PCaddr_out;
    logic [63:0] se_o;
    logic [4:0]  Rn_out;
    logic [4:0]  Rm_out;
    logic [4:0]  Rd_out;
    logic [5:0]  cntrl_EX_out;
    logic [4:0]  cntrl_M_out;
    logic [1:0]  cntrl_WB_out;

    // EX/MEM
    logic        ex_mem_enable;
    logic [63:0] ALUresult;
    logic [63:0] WriteData;
    logic [63:0] addr;
    logic [4:0]  Rd_em;
    logic [1:0]  WB;
    logic [4:0]  M;
    logic [3:0]  alu_flag;
    logic [3:0]  flag;
    logic [63:0] ALUresult_out;
    logic [63:0] WriteData_out;
    logic [63:0] addr_out;
    logic [4:0]  Rd_em_out;
    logic [1:0]  WB_out;
    logic [4:0]  M_out;
    logic [3:0]  alu_flag_out;
    logic [3:0]  flag_out;

`ifdef PIPE_FLUSH_EN
    logic        if_id_flush;
    logic        id_ex_flush;
`endif

    modport slave (
        input  if_id_enable, instr, pcaddr,
        output instr_out, pcaddr_out,
        input  id_ex_enable, ReadData1, ReadData2, PCaddr, se, Rn, Rm, Rd,
        input  cntrl_EX, cntrl_M, cntrl_WB,
        output RD1_out, RD2_out, PCaddr_out, se_o, Rn_out, Rm_out, Rd_out,
        output cntrl_EX_out, cntrl_M_out, cntrl_WB_out,
        input  ex_mem_enable, ALUresult, WriteData, addr, Rd_em, WB, M,
        input  alu_flag, flag,
        output ALUresult_out, WriteData_out, addr_out, Rd_em_out, WB_out,
        output M_out, alu_flag_out, flag_out
`ifdef PIPE_FLUSH_EN
        ,
        input  if_id_flush, id_ex_flush
`endif
    );

    modport master (
        output if_id_enable, instr, pcaddr,
        input  instr_out, pcaddr_out,
        output id_ex_enable, ReadData1, ReadData2, PCaddr, se, Rn, Rm, Rd,
        output cntrl_EX, cntrl_M, cntrl_WB,
        input  RD1_out, RD2_out, PCaddr_out, se_o, Rn_out, Rm_out, Rd_out,
        input  cntrl_EX_out, cntrl_M_out, cntrl_WB_out,
        output ex_mem_enable, ALUresult, WriteData, addr, Rd_em, WB, M,
        output alu_flag, flag,
        input  ALUresult_out, WriteData_out, addr_out, Rd_em_out, WB_out,
        input  M_out, alu_flag_out, flag_out
`ifdef PIPE_FLUSH_EN
        ,
        output if_id_flush, id_ex_flush
`endif
    );

endinterface : pipeline_regs_if
`default_nettype wire

// File: rtl/pipeline_regs.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_regs
//  Description : IF/ID, ID/EX and EX/MEM inter-stage registers for the
//                5-stage 64-bit pipeline. Each bank has its own load enable
//                so stall logic can freeze any stage; rst is asynchronous
//                and active-high and clears every bank.
//                Optional macro PIPE_FLUSH_EN: adds synchronous flush inputs
//                for IF/ID and ID/EX that load zeros (a bubble) and take
//                priority over the load enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_regs (
    input  wire logic         clk,
    input  wire logic         rst,
    pipeline_regs_if.slave    bus
);

    // ---------------- IF/ID state ----------------
    logic [31:0] r_instr;
    logic [63:0] r_pcaddr;

    // ---------------- ID/EX state ----------------
    logic [63:0] r_rd1;
    logic [63:0] r_rd2;
    logic [63:0] r_pc_ex;
    logic [63:0] r_se;
    logic [4:0]  r_rn;
    logic [4:0]  r_rm;
    logic [4:0]  r_rd;
    logic [5:0]  r_cntrl_ex;
    logic [4:0]  r_cntrl_m;
    logic [1:0]  r_cntrl_wb;

    // ---------------- EX/MEM state ---------------
    logic [63:0] r_alu_result;
    logic [63:0] r_write_data;
    logic [63:0] r_addr;
    logic [4:0]  r_rd_em;
    logic [1:0]  r_wb;
    logic [4:0]  r_m;
    logic [3:0]  r_alu_flag;
    logic [3:0]  r_flag;

    // Flush requests collapse to constant 0 when the feature is not built,
    // so the register processes below stay identical in both builds.
    logic w_if_id_flush;
    logic w_id_ex_flush;
`ifdef PIPE_FLUSH_EN
    assign w_if_id_flush = bus.if_id_flush;
    assign w_id_ex_flush = bus.id_ex_flush;
`else
    assign w_if_id_flush = 1'b0;
    assign w_id_ex_flush = 1'b0;
`endif

    // IF/ID bank: reset > flush > enable > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr  <= '0;
            r_pcaddr <= '0;
        end else if (w_if_id_flush) begin
            r_instr  <= '0;
            r_pcaddr <= '0;
        end else if (bus.if_id_enable) begin
            r_instr  <= bus.instr;
            r_pcaddr <= bus.pcaddr;
        end
    end

    // ID/EX bank: reset > flush > enable > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_pc_ex    <= '0;
            r_se       <= '0;
            r_rn       <= '0;
            r_rm       <= '0;
            r_rd       <= '0;
            r_cntrl_ex <= '0;
            r_cntrl_m  <= '0;
            r_cntrl_wb <= '0;
        end else if (w_id_ex_flush) begin
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_pc_ex    <= '0;
            r_se       <= '0;
            r_rn       <= '0;
            r_rm       <= '0;
            r_rd       <= '0;
            r_cntrl_ex <= '0;
            r_cntrl_m  <= '0;
            r_cntrl_wb <= '0;
        end else if (bus.id_ex_enable) begin
            r_rd1      <= bus.ReadData1;
            r_rd2      <= bus.ReadData2;
            r_pc_ex    <= bus.PCaddr;
            r_se       <= bus.se;
            r_rn       <= bus.Rn;
            r_rm       <= bus.Rm;
            r_rd       <= bus.Rd;
            r_cntrl_ex <= bus.cntrl_EX;
            r_cntrl_m  <= bus.cntrl_M;
            r_cntrl_wb <= bus.cntrl_WB;
        end
    end

    // EX/MEM bank: reset > enable > hold (no flush on this stage)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_result <= '0;
            r_write_data <= '0;
            r_addr       <= '0;
            r_rd_em      <= '0;
            r_wb         <= '0;
            r_m          <= '0;
            r_alu_flag   <= '0;
            r_flag       <= '0;
        end else if (bus.ex_mem_enable) begin
            r_alu_result <= bus.ALUresult;
            r_write_data <= bus.WriteData;
            r_addr       <= bus.addr;
            r_rd_em      <= bus.Rd_em;
            r_wb         <= bus.WB;
            r_m          <= bus.M;
            r_alu_flag   <= bus.alu_flag;
            r_flag       <= bus.flag;
        end
    end

    // Outputs are straight register copies: no input-to-output path.
    assign bus.instr_out     = r_instr;
    assign bus.pcaddr_out    = r_pcaddr;

    assign bus.RD1_out       = r_rd1;
    assign bus.RD2_out       = r_rd2;
    assign bus.PCaddr_out    = r_pc_ex;
    assign bus.se_o          = r_se;
    assign bus.Rn_out        = r_rn;
    assign bus.Rm_out        = r_rm;
    assign bus.Rd_out        = r_rd;
    assign bus.cntrl_EX_out  = r_cntrl_ex;
    assign bus.cntrl_M_out   = r_cntrl_m;
    assign bus.cntrl_WB_out  = r_cntrl_wb;

    assign bus.ALUresult_out = r_alu_result;
    assign bus.WriteData_out = r_write_data;
    assign bus.addr_out      = r_addr;
    assign bus.Rd_em_out     = r_rd_em;
    assign bus.WB_out        = r_wb;
    assign bus.M_out         = r_m;
    assign bus.alu_flag_out  = r_alu_flag;
    assign bus.flag_out      = r_flag;

endmodule : pipeline_regs
`default_nettype wire

// File: tb/tb_pipeline_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_regs
//  Description : Directed self-checking bench for pipeline_regs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_regs;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    pipeline_regs_if pif ();

    pipeline_regs dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // compare one observed value against the bench's expected value
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".instr_out"},     64'(pif.instr_out),     64'd0);
        check({tag, ".pcaddr_out"},    pif.pcaddr_out,         64'd0);
        check({tag, ".RD1_out"},       pif.RD1_out,            64'd0);
        check({tag, ".RD2_out"},       pif.RD2_out,            64'd0);
        check({tag, ".PCaddr_out"},    pif.PCaddr_out,         64'd0);
        check({tag, ".se_o"},          pif.se_o,               64'd0);
        check({tag, ".Rn_out"},        64'(pif.Rn_out),        64'd0);
        check({tag, ".Rm_out"},        64'(pif.Rm_out),        64'd0);
        check({tag, ".Rd_out"},        64'(pif.Rd_out),        64'd0);
        check({tag, ".cntrl_EX_out"},  64'(pif.cntrl_EX_out),  64'd0);
        check({tag, ".cntrl_M_out"},   64'(pif.cntrl_M_out),   64'd0);
        check({tag, ".cntrl_WB_out"},  64'(pif.cntrl_WB_out),  64'd0);
        check({tag, ".ALUresult_out"}, pif.ALUresult_out,      64'd0);
        check({tag, ".WriteData_out"}, pif.WriteData_out,      64'd0);
        check({tag, ".addr_out"},      pif.addr_out,           64'd0);
        check({tag, ".Rd_em_out"},     64'(pif.Rd_em_out),     64'd0);
        check({tag, ".WB_out"},        64'(pif.WB_out),        64'd0);
        check({tag, ".M_out"},         64'(pif.M_out),         64'd0);
        check({tag, ".alu_flag_out"},  64'(pif.alu_flag_out),  64'd0);
        check({tag, ".flag_out"},      64'(pif.flag_out),      64'd0);
    endtask

    task automatic drive_random();
        pif.instr     = $urandom;
        pif.pcaddr    = {$urandom, $urandom};
        pif.ReadData1 = {$urandom, $urandom};
        pif.ReadData2 = {$urandom, $urandom};
        pif.PCaddr    = {$urandom, $urandom};
        pif.se        = {$urandom, $urandom};
        pif.Rn        = 5'($urandom);
        pif.Rm        = 5'($urandom);
        pif.Rd        = 5'($urandom);
        pif.cntrl_EX  = 6'($urandom);
        pif.cntrl_M   = 5'($urandom);
        pif.cntrl_WB  = 2'($urandom);
        pif.ALUresult = {$urandom, $urandom};
        pif.WriteData = {$urandom, $urandom};
        pif.addr      = {$urandom, $urandom};
        pif.Rd_em     = 5'($urandom);
        pif.WB        = 2'($urandom);
        pif.M         = 5'($urandom);
        pif.alu_flag  = 4'($urandom);
        pif.flag      = 4'($urandom);
    endtask

    // watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v_instr;
        n_total = 0;
        n_bad   = 0;

        pif.if_id_enable  = 1'b0;
        pif.id_ex_enable  = 1'b0;
        pif.ex_mem_enable = 1'b0;
`ifdef PIPE_FLUSH_EN
        pif.if_id_flush   = 1'b0;
        pif.id_ex_flush   = 1'b0;
`endif
        drive_random();

        // reset state, including across a clock edge with rst held
        rst = 1'b1;
        #2;
        check_all_zero("rst_init");
        tick();
        check_all_zero("rst_init_edge");
        rst = 1'b0;

        // load random data, then assert reset between edges
        pif.if_id_enable  = 1'b1;
        pif.id_ex_enable  = 1'b1;
        pif.ex_mem_enable = 1'b1;
        drive_random();
        pif.instr = 32'hDEAD_BEEF;
        tick();
        check("rand_load.instr_out", 64'(pif.instr_out), 64'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        tick();
        check_all_zero("rst_hold");
        tick();
        check_all_zero("rst_hold2");
        rst = 1'b0;

        // IF/ID load
        pif.id_ex_enable  = 1'b0;
        pif.ex_mem_enable = 1'b0;
        pif.instr  = 32'h8B02_0020;
        pif.pcaddr = 64'h10;
        tick();
        check("ifid.instr_out",  64'(pif.instr_out), 64'h8B02_0020);
        check("ifid.pcaddr_out", pif.pcaddr_out,     64'h10);
        // input change mid-cycle must not reach the output
        pif.instr = 32'h1234_5678;
        #2;
        check("ifid.no_comb", 64'(pif.instr_out), 64'h8B02_0020);
        // hold with enable low
        pif.if_id_enable = 1'b0;
        tick();
        check("ifid.hold", 64'(pif.instr_out), 64'h8B02_0020);
        // disabled stages were not disturbed by the IF/ID activity
        check("ifid.idex_idle",  64'(pif.Rd_out), 64'd0);
        check("ifid.exmem_idle", pif.ALUresult_out, 64'd0);

        // pipeline flow of WB control: ID/EX at edge 1, EX/MEM at edge 2
        pif.id_ex_enable  = 1'b1;
        pif.ex_mem_enable = 1'b1;
        pif.cntrl_WB = 2'b10;
        pif.WB       = 2'b00;
        tick();
        check("flow.cntrl_WB_out_e1", 64'(pif.cntrl_WB_out), 64'd2);
        check("flow.WB_out_e1",       64'(pif.WB_out),       64'd0);
        pif.WB       = pif.cntrl_WB_out;
        pif.cntrl_WB = 2'b00;
        tick();
        check("flow.WB_out_e2",       64'(pif.WB_out),       64'd2);
        check("flow.cntrl_WB_out_e2", 64'(pif.cntrl_WB_out), 64'd0);

        // full ID/EX vector
        pif.ex_mem_enable = 1'b0;
        pif.ReadData1 = 64'h0123_4567_89AB_CDEF;
        pif.ReadData2 = 64'hFEDC_BA98_7654_3210;
        pif.PCaddr    = 64'h0000_0000_0000_0404;
        pif.se        = 64'hFFFF_FFFF_FFFF_FFF0;
        pif.Rn        = 5'd2;
        pif.Rm        = 5'd30;
        pif.Rd        = 5'd1;
        pif.cntrl_EX  = 6'b101_010;
        pif.cntrl_M   = 5'b10110;
        pif.cntrl_WB  = 2'b01;
        tick();
        check("idex.RD1_out",      pif.RD1_out,            64'h0123_4567_89AB_CDEF);
        check("idex.RD2_out",      pif.RD2_out,            64'hFEDC_BA98_7654_3210);
        check("idex.PCaddr_out",   pif.PCaddr_out,         64'h404);
        check("idex.se_o",         pif.se_o,               64'hFFFF_FFFF_FFFF_FFF0);
        check("idex.Rn_out",       64'(pif.Rn_out),        64'd2);
        check("idex.Rm_out",       64'(pif.Rm_out),        64'd30);
        check("idex.Rd_out",       64'(pif.Rd_out),        64'd1);
        check("idex.cntrl_EX_out", 64'(pif.cntrl_EX_out),  64'h2A);
        check("idex.cntrl_M_out",  64'(pif.cntrl_M_out),   64'h16);
        check("idex.cntrl_WB_out", 64'(pif.cntrl_WB_out),  64'd1);
        check("idex.exmem_held",   64'(pif.WB_out),        64'd2);

        // stall ID/EX for 3 edges while IF/ID keeps loading
        pif.id_ex_enable = 1'b0;
        pif.if_id_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pif.Rd  = (i % 2 == 0) ? 5'd3 : 5'd7;
            v_instr = 32'hA000_0000 + 32'(i);
            pif.instr = v_instr;
            tick();
            check("stall.Rd_out",    64'(pif.Rd_out),    64'd1);
            check("stall.instr_out", 64'(pif.instr_out), 64'(v_instr));
        end
        pif.id_ex_enable = 1'b1;
        tick();
        check("stall.release", 64'(pif.Rd_out), 64'd3);

        // EX/MEM flags and data
        pif.if_id_enable  = 1'b0;
        pif.id_ex_enable  = 1'b0;
        pif.ex_mem_enable = 1'b1;
        pif.alu_flag  = 4'b1010;
        pif.flag      = 4'b0101;
        pif.ALUresult = 64'hFFFF_FFFF_FFFF_FFF8;
        pif.WriteData = 64'h5555_AAAA_5555_AAAA;
        pif.addr      = 64'h0000_0000_0000_1000;
        pif.Rd_em     = 5'd31;
        pif.M         = 5'b10101;
        pif.WB        = 2'b11;
        tick();
        check("exmem.alu_flag_out",  64'(pif.alu_flag_out), 64'hA);
        check("exmem.flag_out",      64'(pif.flag_out),     64'h5);
        check("exmem.ALUresult_out", pif.ALUresult_out,     64'hFFFF_FFFF_FFFF_FFF8);
        check("exmem.WriteData_out", pif.WriteData_out,     64'h5555_AAAA_5555_AAAA);
        check("exmem.addr_out",      pif.addr_out,          64'h1000);
        check("exmem.Rd_em_out",     64'(pif.Rd_em_out),    64'd31);
        check("exmem.M_out",         64'(pif.M_out),        64'h15);
        check("exmem.WB_out",        64'(pif.WB_out),       64'd3);
        check("exmem.ifid_held",     64'(pif.instr_out),    64'hA000_0002);
        pif.ex_mem_enable = 1'b0;
        pif.ALUresult = 64'd7;
        tick();
        check("exmem.hold", pif.ALUresult_out, 64'hFFFF_FFFF_FFFF_FFF8);

`ifdef PIPE_FLUSH_EN
        // flush overrides enable and loads a bubble
        pif.if_id_enable = 1'b1;
        pif.if_id_flush  = 1'b1;
        pif.instr  = 32'hFFFF_FFFF;
        pif.pcaddr = 64'h20;
        tick();
        check("flush.instr_out",  64'(pif.instr_out), 64'd0);
        check("flush.pcaddr_out", pif.pcaddr_out,     64'd0);
        check("flush.idex_kept",  64'(pif.Rd_out),    64'd3);
        pif.if_id_flush  = 1'b0;
        pif.id_ex_enable = 1'b0;
        pif.id_ex_flush  = 1'b1;
        tick();
        check("flush.Rd_out",       64'(pif.Rd_out),       64'd0);
        check("flush.cntrl_M_out",  64'(pif.cntrl_M_out),  64'd0);
        check("flush.instr_reload", 64'(pif.instr_out),    64'hFFFF_FFFF);
        pif.id_ex_flush = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pipeline_regs
`default_nettype wire
